// File: rtl/branch_predictor_pkg.sv
// Shared branch definitions: opcode encoding (also used by the execute-stage
// branch comparator), opcode class helpers and the 2-bit counter states.
package branch_predictor_pkg;

    localparam logic [4:0] BR_EQ  = 5'b01000;
    localparam logic [4:0] BR_NE  = 5'b01001;
    localparam logic [4:0] BR_LT  = 5'b01100;
    localparam logic [4:0] BR_GE  = 5'b01101;
    localparam logic [4:0] BR_LTU = 5'b01110;
    localparam logic [4:0] BR_GEU = 5'b01111;
    localparam logic [4:0] BR_JMP = 5'b11111;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_state_e;

    function automatic logic is_cond_branch(input logic [4:0] op);
        logic res;
        case (op)
            BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU: res = 1'b1;
            default:                                   res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic is_branch(input logic [4:0] op);
        return is_cond_branch(op) || (op == BR_JMP);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, execute resolution report and status outputs of the predictor.
// master = pipeline side, slave = predictor side.
interface branch_predictor_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             fetch_valid;
    logic [XLEN-1:0]  fetch_pc;
    logic             pred_valid;
    logic             pred_taken;
    logic             upd_valid;
    logic [XLEN-1:0]  upd_pc;
    logic [4:0]       upd_br_op;
    logic             upd_taken;
    logic             upd_pred_taken;
    logic             mispredict;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    modport master (
        output fetch_valid, fetch_pc,
        output upd_valid, upd_pc, upd_br_op, upd_taken, upd_pred_taken,
        input  pred_valid, pred_taken, mispredict, branch_cnt, mispred_cnt
    );

    modport slave (
        input  fetch_valid, fetch_pc,
        input  upd_valid, upd_pc, upd_br_op, upd_taken, upd_pred_taken,
        output pred_valid, pred_taken, mispredict, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  ctr_state_e state,
    input  logic       taken,
    output ctr_state_e next_state
);

    always_comb begin
        next_state = state;
        case (state)
            CTR_SNT: next_state = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: next_state = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  next_state = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  next_state = taken ? CTR_ST  : CTR_WT;
            default: next_state = state;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch direction predictor: PC-indexed table of 2-bit counters with
// registered lookup, training from execute, mispredict flag and perf counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int IDX_BITS = 6,
    parameter int CNT_W    = 16
) (
    input logic                clk,
    input logic                rst,
    branch_predictor_if.slave  bus
);

    localparam int ENTRIES = 1 << IDX_BITS;

    ctr_state_e           ctr_table [ENTRIES];
    logic [IDX_BITS-1:0]  fetch_idx;
    logic [IDX_BITS-1:0]  upd_idx;
    ctr_state_e           upd_next;
    ctr_state_e           fetch_ctr;
    logic                 train;
    logic                 upd_mispred;
    logic                 upd_is_branch;

    logic                 pred_valid_q;
    logic                 pred_taken_q;
    logic                 mispredict_q;
    logic [CNT_W-1:0]     branch_cnt_q;
    logic [CNT_W-1:0]     mispred_cnt_q;

    logic                 unused_pc_bits;

    assign fetch_idx = bus.fetch_pc[IDX_BITS+1:2];
    assign upd_idx   = bus.upd_pc[IDX_BITS+1:2];
    assign unused_pc_bits = ^{bus.fetch_pc[XLEN-1:IDX_BITS+2], bus.fetch_pc[1:0],
                              bus.upd_pc[XLEN-1:IDX_BITS+2], bus.upd_pc[1:0]};

    assign train         = bus.upd_valid && is_cond_branch(bus.upd_br_op);
    assign upd_is_branch = bus.upd_valid && is_branch(bus.upd_br_op);

    sat_counter2 u_upd_ctr (
        .state      (ctr_table[upd_idx]),
        .taken      (bus.upd_taken),
        .next_state (upd_next)
    );

    // Write-first: a same-index lookup sees the value being written this edge.
    always_comb begin
        fetch_ctr = ctr_table[fetch_idx];
        if (train && (fetch_idx == upd_idx))
            fetch_ctr = upd_next;
    end

    always_comb begin
        upd_mispred = 1'b0;
        if (bus.upd_valid) begin
            if (is_cond_branch(bus.upd_br_op))
                upd_mispred = (bus.upd_taken != bus.upd_pred_taken);
            else if (bus.upd_br_op == BR_JMP)
                upd_mispred = !bus.upd_pred_taken;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                ctr_table[i] <= CTR_WNT;
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            mispredict_q  <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            pred_valid_q <= bus.fetch_valid;
            pred_taken_q <= bus.fetch_valid & fetch_ctr[1];
            if (train)
                ctr_table[upd_idx] <= upd_next;
            mispredict_q <= upd_mispred;
            // Perf counters stick at all-ones rather than wrapping.
            if (upd_is_branch && (branch_cnt_q != '1))
                branch_cnt_q <= branch_cnt_q + CNT_W'(1);
            if (upd_mispred && (mispred_cnt_q != '1))
                mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
        end
    end

    assign bus.pred_valid  = pred_valid_q;
    assign bus.pred_taken  = pred_taken_q;
    assign bus.mispredict  = mispredict_q;
    assign bus.branch_cnt  = branch_cnt_q;
    assign bus.mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random
// traffic against an integer-array reference model.
module tb_branch_predictor;

    logic clk = 1'b0;
    logic rst = 1'b1;

    branch_predictor_if #(.XLEN(32), .CNT_W(16)) bp ();

    branch_predictor #(.XLEN(32), .IDX_BITS(6), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bp)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: counters held as plain integers 0..3.
    int tbl [64];
    bit e_pv, e_pt, e_mp;
    int e_bc, e_mc;

    function automatic bit m_cond(input int op);
        return (op == 8) || (op == 9) || (op >= 12 && op <= 15);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) tbl[i] = 1;
        e_pv = 0; e_pt = 0; e_mp = 0; e_bc = 0; e_mc = 0;
    endtask

    task automatic model_clock();
        int fi, ui, op;
        if (rst) begin
            model_reset();
            return;
        end
        fi = int'((bp.fetch_pc >> 2) % 64);
        ui = int'((bp.upd_pc >> 2) % 64);
        op = int'(bp.upd_br_op);
        if (bp.upd_valid && m_cond(op))
            tbl[ui] = bp.upd_taken ? ((tbl[ui] == 3) ? 3 : tbl[ui] + 1)
                                   : ((tbl[ui] == 0) ? 0 : tbl[ui] - 1);
        e_pv = bp.fetch_valid;
        e_pt = bp.fetch_valid && (tbl[fi] >= 2);
        e_mp = bp.upd_valid && ((m_cond(op) && (bp.upd_taken != bp.upd_pred_taken)) ||
                                (op == 31 && !bp.upd_pred_taken));
        if (bp.upd_valid && (m_cond(op) || op == 31) && e_bc < 65535) e_bc++;
        if (e_mp && e_mc < 65535) e_mc++;
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bp.fetch_valid = 0; bp.fetch_pc = '0;
        bp.upd_valid = 0; bp.upd_pc = '0; bp.upd_br_op = '0;
        bp.upd_taken = 0; bp.upd_pred_taken = 0;
    endtask

    task automatic set_fetch(input bit v, input logic [31:0] pc);
        bp.fetch_valid = v; bp.fetch_pc = pc;
    endtask

    task automatic set_upd(input bit v, input logic [31:0] pc, input logic [4:0] op,
                           input bit t, input bit p);
        bp.upd_valid = v; bp.upd_pc = pc; bp.upd_br_op = op;
        bp.upd_taken = t; bp.upd_pred_taken = p;
    endtask

    task automatic test_reset();
        idle();
        model_reset();
        #3;
        checks++;
        if ({bp.pred_valid, bp.pred_taken, bp.mispredict} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b expected 000", {bp.pred_valid, bp.pred_taken, bp.mispredict});
        end
        checks++;
        if (bp.branch_cnt !== 16'd0 || bp.mispred_cnt !== 16'd0) begin
            failures++;
            $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", bp.branch_cnt, bp.mispred_cnt);
        end
        repeat (2) @(posedge clk);
        #1 rst = 0;
        set_fetch(1, 32'h100);
        tick();
        checks++;
        if (bp.pred_valid !== 1'b1 || bp.pred_taken !== 1'b0) begin
            failures++;
            $display("[TB] FAIL first_lookup: got valid=%b taken=%b expected valid=1 taken=0", bp.pred_valid, bp.pred_taken);
        end
        checks++;
        if (bp.mispredict !== 1'b0 || bp.branch_cnt !== 16'd0 || bp.mispred_cnt !== 16'd0) begin
            failures++;
            $display("[TB] FAIL first_lookup_status: got mp=%b bc=%0d mc=%0d expected 0/0/0", bp.mispredict, bp.branch_cnt, bp.mispred_cnt);
        end
    endtask

    task automatic test_training();
        idle();
        set_upd(1, 32'h100, 5'b01000, 1, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bp.mispredict !== 1'b1) begin
                failures++;
                $display("[TB] FAIL train_mispredict%0d: got %b expected 1", i, bp.mispredict);
            end
        end
        idle();
        set_fetch(1, 32'h100);
        tick();
        checks++;
        if (bp.pred_taken !== 1'b1 || bp.mispredict !== 1'b0) begin
            failures++;
            $display("[TB] FAIL train_predict: got taken=%b mp=%b expected taken=1 mp=0", bp.pred_taken, bp.mispredict);
        end
        set_fetch(1, 32'h200);
        tick();
        checks++;
        if (bp.pred_taken !== 1'b1) begin
            failures++;
            $display("[TB] FAIL alias_predict: got %b expected 1", bp.pred_taken);
        end
        checks++;
        if (bp.branch_cnt !== 16'd2 || bp.mispred_cnt !== 16'd2) begin
            failures++;
            $display("[TB] FAIL train_counters: got bc=%0d mc=%0d expected 2/2", bp.branch_cnt, bp.mispred_cnt);
        end
    endtask

    task automatic test_hysteresis();
        bit exp_pt [6] = '{1, 0, 0, 0, 0, 0};
        for (int i = 0; i < 6; i++) begin
            idle();
            if (i < 5) set_upd(1, 32'h100, 5'b01101, 0, 1);
            else       set_upd(1, 32'h100, 5'b01101, 1, 0);
            tick();
            idle();
            set_fetch(1, 32'h100);
            tick();
            checks++;
            if (bp.pred_taken !== exp_pt[i]) begin
                failures++;
                $display("[TB] FAIL hysteresis_step%0d: got %b expected %b", i, bp.pred_taken, exp_pt[i]);
            end
        end
    endtask

    task automatic test_bypass();
        idle();
        set_fetch(1, 32'h14);
        set_upd(1, 32'h14, 5'b01110, 1, 0);
        tick();
        checks++;
        if (bp.pred_taken !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bypass: got %b expected 1", bp.pred_taken);
        end
        idle();
        set_fetch(1, 32'h14);
        tick();
        checks++;
        if (bp.pred_taken !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bypass_written: got %b expected 1", bp.pred_taken);
        end
    endtask

    task automatic test_uncond_nonbranch();
        logic [15:0] bc_before;
        idle();
        set_upd(1, 32'h20, 5'b11111, 1, 0);
        tick();
        checks++;
        if (bp.mispredict !== 1'b1) begin
            failures++;
            $display("[TB] FAIL jmp_not_predicted: got %b expected 1", bp.mispredict);
        end
        set_upd(1, 32'h20, 5'b11111, 0, 1);
        tick();
        checks++;
        if (bp.mispredict !== 1'b0) begin
            failures++;
            $display("[TB] FAIL jmp_predicted: got %b expected 0", bp.mispredict);
        end
        idle();
        set_fetch(1, 32'h20);
        tick();
        checks++;
        if (bp.pred_taken !== 1'b0) begin
            failures++;
            $display("[TB] FAIL jmp_no_train: got %b expected 0", bp.pred_taken);
        end
        bc_before = bp.branch_cnt;
        idle();
        set_upd(1, 32'h20, 5'b00000, 1, 0);
        tick();
        set_upd(1, 32'h20, 5'b01010, 1, 0);
        tick();
        checks++;
        if (bp.mispredict !== 1'b0 || bp.branch_cnt !== bc_before || bp.branch_cnt !== 16'(e_bc)) begin
            failures++;
            $display("[TB] FAIL nonbranch: got mp=%b bc=%0d expected mp=0 bc=%0d", bp.mispredict, bp.branch_cnt, e_bc);
        end
        checks++;
        if (bp.mispred_cnt !== 16'(e_mc)) begin
            failures++;
            $display("[TB] FAIL nonbranch_mc: got %0d expected %0d", bp.mispred_cnt, e_mc);
        end
    endtask

    task automatic test_random();
        logic [4:0] ops [10] = '{5'd8, 5'd9, 5'd12, 5'd13, 5'd14, 5'd15, 5'd31, 5'd0, 5'd10, 5'd30};
        int errs = 0;
        for (int i = 0; i < 400; i++) begin
            set_fetch(1'($urandom), ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2));
            set_upd(1'($urandom), ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2),
                    ops[$urandom_range(0, 9)], 1'($urandom), 1'($urandom));
            tick();
            checks++;
            if (bp.pred_valid !== e_pv || bp.pred_taken !== e_pt || bp.mispredict !== e_mp ||
                bp.branch_cnt !== 16'(e_bc) || bp.mispred_cnt !== 16'(e_mc)) begin
                failures++;
                errs++;
                if (errs < 10)
                    $display("[TB] FAIL random_cycle%0d: got pv=%b pt=%b mp=%b bc=%0d mc=%0d expected pv=%b pt=%b mp=%b bc=%0d mc=%0d",
                             i, bp.pred_valid, bp.pred_taken, bp.mispredict, bp.branch_cnt, bp.mispred_cnt,
                             e_pv, e_pt, e_mp, e_bc, e_mc);
            end
        end
        idle();
    endtask

    task automatic test_reset_midstream();
        idle();
        set_fetch(1, 32'h100);
        set_upd(1, 32'h100, 5'b11111, 0, 0);
        tick();
        #2 rst = 1;
        #1;
        model_reset();
        checks++;
        if ({bp.pred_valid, bp.pred_taken, bp.mispredict} !== 3'b000 ||
            bp.branch_cnt !== 16'd0 || bp.mispred_cnt !== 16'd0) begin
            failures++;
            $display("[TB] FAIL async_reset: got pv=%b pt=%b mp=%b bc=%0d mc=%0d expected all 0",
                     bp.pred_valid, bp.pred_taken, bp.mispredict, bp.branch_cnt, bp.mispred_cnt);
        end
        tick();
        checks++;
        if (bp.pred_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_hold: got %b expected 0", bp.pred_valid);
        end
        rst = 0;
        idle();
        tick();
        checks++;
        if (bp.pred_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL post_reset_idle: got %b expected 0", bp.pred_valid);
        end
        set_upd(1, 32'h100, 5'b01001, 1, 1);
        tick();
        idle();
        set_fetch(1, 32'h100);
        tick();
        checks++;
        if (bp.pred_valid !== 1'b1 || bp.pred_taken !== 1'b1) begin
            failures++;
            $display("[TB] FAIL table_reinit: got valid=%b taken=%b expected 1/1", bp.pred_valid, bp.pred_taken);
        end
    endtask

    task automatic test_saturation();
        idle();
        set_upd(1, 32'h40, 5'b11111, 1, 0);
        while (e_bc < 65534) tick();
        checks++;
        if (bp.branch_cnt !== 16'hFFFE) begin
            failures++;
            $display("[TB] FAIL bc_fffe: got %h expected fffe", bp.branch_cnt);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bp.branch_cnt !== 16'hFFFF || bp.mispred_cnt !== 16'(e_mc)) begin
                failures++;
                $display("[TB] FAIL saturate%0d: got bc=%h mc=%h expected bc=ffff mc=%h", i, bp.branch_cnt, bp.mispred_cnt, e_mc);
            end
        end
        checks++;
        if (bp.mispred_cnt !== 16'hFFFF) begin
            failures++;
            $display("[TB] FAIL mc_saturate: got %h expected ffff", bp.mispred_cnt);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_training();
        test_hysteresis();
        test_bypass();
        test_uncond_nonbranch();
        test_random();
        test_reset_midstream();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch direction predictor. It is the consumer of the branch decision produced by the execute-stage branch comparator.
- Fetch queries a table of 2-bit saturating counters indexed by PC and gets a registered taken/not-taken prediction.
- Execute reports the resolved outcome with the branch opcode. The block trains the table, flags mispredictions for pipeline flush, and keeps saturating performance counters.

Parameters:
- XLEN, 32, PC width.
- IDX_BITS, 6, log2 of table entries (64 entries); index = pc[IDX_BITS+1:2].
- CNT_W, 16, width of performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_valid  in  1  lookup request this cycle.
- fetch_pc  in  XLEN  PC of the instruction being fetched.
- pred_valid  out  1  prediction valid; registered copy of fetch_valid.
- pred_taken  out  1  predicted direction for the previous cycle's fetch_pc.
- upd_valid  in  1  resolved branch report from execute.
- upd_pc  in  XLEN  PC of the resolved instruction.
- upd_br_op  in  5  branch opcode, same encoding as the branch comparator.
- upd_taken  in  1  actual outcome (comparator "branch" output).
- upd_pred_taken  in  1  prediction that was made for this instruction (carried down the pipe).
- mispredict  out  1  one-cycle pulse: the resolved branch was mispredicted.
- branch_cnt  out  CNT_W  number of resolved branch-class reports.
- mispred_cnt  out  CNT_W  number of mispredictions.

Behaviour:
- Opcode classes (constants):
  - Conditional: 01000 EQ, 01001 NE, 01100 LT, 01101 GE, 01110 LTU, 01111 GEU.
  - Unconditional: 11111.
  - All other codes are non-branch.
- Reset (async, immediate):
  - All table entries = 2'b01 (weakly not-taken).
  - pred_valid=0, pred_taken=0, mispredict=0, branch_cnt=0, mispred_cnt=0.
- Counter states and transitions: 00 SNT, 01 WNT, 10 WT, 11 ST.
  - Taken: increment, saturating at 11.
  - Not-taken: decrement, saturating at 00.
  - Prediction = MSB of the counter.
- Lookup timing, 1-cycle latency:
  - On the clock edge, pred_valid <= fetch_valid and pred_taken <= fetch_valid & entry[fetch_pc idx].MSB.
  - When fetch_valid=0, pred_taken is 0.
- Training:
  - Only when upd_valid=1 and upd_br_op is conditional.
  - The entry at the upd_pc index is updated at the clock edge.
  - Unconditional and non-branch ops never write the table.
- Read/write collision: if fetch and update target the same index in the same cycle, the prediction uses the post-update counter value (write-first bypass).
- Aliasing: PCs differing only above bit IDX_BITS+1 share an entry. This is intended.
- mispredict is registered and asserted the cycle after upd_valid when either:
  - the op is conditional and upd_taken != upd_pred_taken; or
  - the op is unconditional and upd_pred_taken == 0.
- Non-branch ops, or upd_valid=0, give mispredict=0. upd_taken is ignored for unconditional ops.
- Performance counters:
  - branch_cnt increments on every upd_valid with a conditional or unconditional op.
  - mispred_cnt increments on the same edge on which mispredict is set.
  - Both saturate at all-ones and do not wrap.
- Fetch and update are independent. Both may be active every cycle; there is no backpressure.
- Reset asserted mid-operation: all state clears immediately. The first valid prediction after release requires a fetch_valid cycle.

Decomposition:
- Shared package holds:
  - the branch opcode constants (BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU, BR_JMP);
  - functions is_cond_branch() and is_branch();
  - the 2-bit counter state constants.
  - The branch comparator and this block both import it.
- One sub-module: sat_counter2, the 2-bit saturating next-state function (counter value plus taken in, next value out). It is instantiated for the update path and reused for the bypass value.

Test Plan:
- Reset then fetch_valid=1, fetch_pc=0x100 -> next cycle pred_valid=1, pred_taken=0; mispredict=0; both counters 0.
- Two conditional updates, upd_pc=0x100, br_op=01000, upd_taken=1, upd_pred_taken=0 -> mispredict pulses both cycles, entry 01->10->11. Next fetch 0x100 -> pred_taken=1. Another fetch at 0x200 (same index with IDX_BITS=6) -> pred_taken=1. mispred_cnt=2, branch_cnt=2.
- Saturation/hysteresis: entry at 11, one not-taken update -> 10, fetch still predicts taken; second not-taken -> 01, predicts not-taken; three more not-taken updates -> stays at 00.
- Same-cycle fetch and update at index 5 (pc 0x14) with entry 01, upd_taken=1 -> pred_taken=1 next cycle (bypass).
- br_op=11111, upd_pred_taken=0 -> mispredict=1, table unchanged. br_op=00000 with upd_valid=1 -> no pulse, counters unchanged.
- Force branch_cnt to 0xFFFE via 0xFFFE updates (or a bench backdoor), then two more updates -> holds at 0xFFFF. Assert rst mid-stream -> all outputs 0 asynchronously, table back to 01.
